// File: rtl/taylor_coef_seq.sv
// Streams the coefficient table 2^W/((2k+1)(2k+2)) over a valid/ready port.
// One beat per cycle with registered outputs; start requests are length-checked.
module taylor_coef_seq #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW:0]      num_terms,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] coef,
    output logic [AW-1:0]    idx,
    output logic             last,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int SLOTS = 1 << AW;
    localparam logic [AW:0] MAX_N = (AW+1)'(DEPTH);

    function automatic logic [WIDTH-1:0] term(input int k);
        int q;
        q = (1 << WIDTH) / ((2 * k + 1) * (2 * k + 2));
        if (q < 1) q = 1;
        return q[WIDTH-1:0];
    endfunction

    // Slots past DEPTH are unreachable; padding keeps idx+1 in range.
    logic [WIDTH-1:0] tbl [SLOTS];
    for (genvar k = 0; k < SLOTS; k++) begin : g_tbl
        if (k < DEPTH) begin : g_used
            assign tbl[k] = term(k);
        end else begin : g_pad
            assign tbl[k] = '0;
        end
    end

    state_t        state;
    logic [AW:0]   n_lat;
    logic [AW-1:0] idx_nxt;
    logic          start_ok;
    logic          fire;

    assign idx_nxt  = idx + 1'b1;
    assign start_ok = (num_terms != '0) && (num_terms <= MAX_N);
    assign fire     = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            n_lat     <= '0;
            out_valid <= 1'b0;
            coef      <= '0;
            idx       <= '0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (start_ok) begin
                            state     <= RUN;
                            n_lat     <= num_terms;
                            idx       <= '0;
                            coef      <= tbl[0];
                            last      <= (num_terms == (AW+1)'(1));
                            out_valid <= 1'b1;
                            busy      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (fire) begin
                        if (last) begin
                            state     <= DONE;
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx  <= idx_nxt;
                            coef <= tbl[idx_nxt];
                            last <= ({1'b0, idx_nxt} == n_lat - 1'b1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/taylor_coef_seq.md
TAYLOR_COEF_SEQ -- requirements
Module: taylor_coef_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, coefficient bit width (4..16).
REQ-002 The block SHALL have parameter DEPTH, default 8, number of table entries (2..64).
REQ-003 The block SHALL have parameter AW, default $clog2(DEPTH), index width.
REQ-004 The block SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 The block SHALL have port start  input  1  request a coefficient sequence; sampled only in IDLE.
REQ-007 The block SHALL have port num_terms  input  AW+1  terms to emit; sampled with start.
REQ-008 The block SHALL have port out_ready  input  1  downstream accepts current coefficient.
REQ-009 The block SHALL have port out_valid  output  1  coef/idx/last are valid.
REQ-010 The block SHALL have port coef  output  WIDTH  current coefficient.
REQ-011 The block SHALL have port idx  output  AW  index k of the current coefficient.
REQ-012 The block SHALL have port last  output  1  current beat is the final term.
REQ-013 The block SHALL have port busy  output  1  high in RUN and DONE.
REQ-014 The block SHALL have port done  output  1  one-cycle pulse after the final handshake.
REQ-015 The block SHALL have port err  output  1  one-cycle pulse on a rejected start.

Function
REQ-016 Table entry k SHALL equal max(1, floor(2^WIDTH / ((2k+1)*(2k+2)))), computed at elaboration; for WIDTH=8 this gives 0x80,0x15,0x08,0x04,0x02,0x01,0x01,0x01.
REQ-017 The FSM SHALL have states IDLE, RUN and DONE, and SHALL be in IDLE after reset.
REQ-018 In IDLE, start=1 with 1<=num_terms<=DEPTH SHALL latch num_terms, clear the index to 0 and enter RUN on the next edge.
REQ-019 In IDLE, start=1 with num_terms=0 or num_terms>DEPTH SHALL pulse err for exactly one cycle (next cycle) and remain in IDLE.
REQ-020 start SHALL be ignored in RUN and DONE; neither err nor a restart SHALL occur.
REQ-021 out_valid SHALL be 1 exactly while in RUN; the first beat (idx=0) SHALL appear the cycle after start is accepted (latency 1).
REQ-022 coef, idx and last SHALL be registered outputs.
REQ-023 coef, idx and last SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 A handshake (out_valid & out_ready) on a non-last beat SHALL advance idx by 1 and update coef on the next cycle, sustaining one beat per cycle when out_ready stays 1.
REQ-025 last SHALL be 1 iff idx = latched num_terms - 1.
REQ-026 A handshake on the last beat SHALL move to DONE, drop out_valid and pulse done for one cycle; DONE SHALL return to IDLE on the following edge.
REQ-027 A new start SHALL be accepted in the cycle after done; the minimum start-to-start spacing is num_terms+2 cycles.
REQ-028 idx SHALL never exceed DEPTH-1; num_terms=DEPTH SHALL emit every entry with no wrap.

Reset
REQ-029 rst_n=0 at a rising edge SHALL force IDLE, out_valid=0, coef=0, idx=0, last=0, busy=0, done=0 and err=0, and SHALL clear the latched num_terms.
REQ-030 Reset asserted mid-RUN SHALL abort the sequence with no done pulse; the first start after rst_n returns to 1 SHALL begin again at idx=0.

Verification
REQ-031 Full sweep (WIDTH=8, DEPTH=8): start with num_terms=8 and out_ready held 1 -> 8 consecutive beats, coef 80,15,08,04,02,01,01,01, last on idx=7, done one cycle later.
REQ-032 Backpressure: num_terms=3, out_ready toggling 1,0,0,1,1 -> coef 80,15,15,15,08, no beat lost or duplicated, done after idx=2 is accepted.
REQ-033 Rejects: start with num_terms=0, then num_terms=9 -> err pulses twice, busy stays 0, out_valid stays 0.
REQ-034 Start while busy: start=1 held throughout a num_terms=2 run -> exactly one sequence runs and err stays 0; a second sequence starts the cycle after done, since start is still held.
REQ-035 Reset mid-run: num_terms=5, rst_n=0 at idx=2 -> all outputs 0 next cycle and no done; a restart emits idx=0 with coef=80.
REQ-036 Width variant: WIDTH=12, DEPTH=4 -> coef 800,155,088,049 (hex).
